// File: rtl/fp16_sched_pkg.sv
`default_nettype none
// ==========================================================================
// fp16_sched_pkg - shared widths, latency and tag helper for fp16_mul_sched
// Rev 1.0
// ==========================================================================
package fp16_sched_pkg;
    localparam int FP16_DW      = 16;
    localparam int FP16_MUL_LAT = 6;

    typedef logic [FP16_DW-1:0] fp16_t;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage
`default_nettype wire

// File: rtl/fp16_mult_wrapper.sv
`default_nettype none
// ==========================================================================
// fp16_mult_wrapper - FP16 multiply (RNE, subnormals flushed), M_LAT stages
// Rev 1.0
// ==========================================================================
module fp16_mult_wrapper
    import fp16_sched_pkg::*;
#(
    parameter int M_LAT = FP16_MUL_LAT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  valid_in,
    input  fp16_t i_a,
    input  fp16_t i_b,
    output logic  valid_out,
    output fp16_t o_result
);
    logic [M_LAT-1:0] r_v;
    fp16_t            r_d [M_LAT];

    function automatic fp16_t fp16_mul(input fp16_t a, input fp16_t b);
        logic              s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
        logic [21:0]       p;
        logic signed [7:0] e;
        logic [10:0]       m;
        logic [11:0]       mr;
        s      = a[15] ^ b[15];
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
        a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
        p      = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e      = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (p[21]) begin
            m  = p[21:11];
            g  = p[10];
            st = |p[9:0];
            e  = e + 8'sd1;
        end else begin
            m  = p[20:10];
            g  = p[9];
            st = |p[8:0];
        end
        mr = {1'b0, m} + {11'd0, g & (st | m[0])};
        if (mr[11]) begin
            mr = mr >> 1;
            e  = e + 8'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) fp16_mul = 16'h7E00;
        else if (a_inf || b_inf)                                     fp16_mul = {s, 5'h1f, 10'd0};
        else if (a_zero || b_zero)                                   fp16_mul = {s, 15'd0};
        else if (e >= 8'sd31)                                        fp16_mul = {s, 5'h1f, 10'd0};
        else if (e <= 8'sd0)                                         fp16_mul = {s, 15'd0};
        else                                                         fp16_mul = {s, e[4:0], mr[9:0]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v <= '0;
            for (int k = 0; k < M_LAT; k++) r_d[k] <= '0;
        end else begin
            r_v[0] <= valid_in;
            r_d[0] <= fp16_mul(i_a, i_b);
            for (int k = 1; k < M_LAT; k++) begin
                r_v[k] <= r_v[k-1];
                r_d[k] <= r_d[k-1];
            end
        end
    end

    assign valid_out = r_v[M_LAT-1];
    assign o_result  = r_d[M_LAT-1];
endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter - one-hot round-robin grant with hold and optional fixed prio 0
// Rev 1.0
// ==========================================================================
module rr_arbiter
    import fp16_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter bit PRIO_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_hold,
    output logic [NREQ-1:0] o_grant
);
    localparam int TW = tag_width(NREQ);

    logic [TW-1:0]   r_ptr;
    logic [TW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_grant;
    logic            w_found;

    // Scan positions ptr, ptr+1, ... and take the first live request.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        if (!i_hold) begin
            if (PRIO_EN && i_req[0]) begin
                w_grant[0] = 1'b1;
                w_found    = 1'b1;
            end
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!w_found && i_req[i] && !(PRIO_EN && i == 0)
                        && (((int'(r_ptr) + k) % NREQ) == i)) begin
                        w_grant[i] = 1'b1;
                        w_found    = 1'b1;
                    end
                end
            end
        end
    end

    // A fixed-priority grant to requester 0 leaves the rotation untouched.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i] && !(PRIO_EN && i == 0)) begin
                w_ptr_nxt = TW'((i + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_grant = w_grant;
endmodule
`default_nettype wire

// File: rtl/fp16_mul_sched.sv
`default_nettype none
// ==========================================================================
// fp16_mul_sched - shares one pipelined FP16 multiplier among NREQ requesters;
// FP16_SCHED_PRIO_EN gives requester 0 fixed priority. Rev 1.0
// ==========================================================================
module fp16_mul_sched
    import fp16_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = FP16_DW,
    parameter int M_LAT = FP16_MUL_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a_flat,
    input  logic [NREQ*DW-1:0] req_b_flat,
    input  logic               hold,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               busy,
    output logic               err
);
    localparam int TW = tag_width(NREQ);
`ifdef FP16_SCHED_PRIO_EN
    localparam bit c_PRIO_EN = 1'b1;
`else
    localparam bit c_PRIO_EN = 1'b0;
`endif

    logic [NREQ-1:0]  w_grant;
    logic [DW-1:0]    w_a, w_b;
    logic [TW-1:0]    w_tag;
    logic             r_vin;
    logic [DW-1:0]    r_a, r_b;
    logic [TW-1:0]    r_tag_in;
    logic [M_LAT-1:0] r_tp_v;
    logic [TW-1:0]    r_tp_tag [M_LAT];
    logic             w_mul_vout;
    fp16_t            w_mul_res;
    logic             w_retire;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [DW-1:0]    r_rsp_data;
    logic             r_err;

    rr_arbiter #(
        .NREQ    (NREQ),
        .PRIO_EN (c_PRIO_EN)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (req_valid),
        .i_hold  (hold),
        .o_grant (w_grant)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_a   = req_a_flat[(i+1)*DW-1 -: DW];
                w_b   = req_b_flat[(i+1)*DW-1 -: DW];
                w_tag = TW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vin    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_tag_in <= '0;
        end else begin
            r_vin <= |w_grant;
            if (|w_grant) begin
                r_a      <= w_a;
                r_b      <= w_b;
                r_tag_in <= w_tag;
            end
        end
    end

    fp16_mult_wrapper #(
        .M_LAT (M_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (r_vin),
        .i_a       (r_a),
        .i_b       (r_b),
        .valid_out (w_mul_vout),
        .o_result  (w_mul_res)
    );

    // The tag pipe mirrors the multiplier depth so its last stage names the owner.
    assign w_retire = w_mul_vout & r_tp_v[M_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tp_v      <= '0;
            for (int k = 0; k < M_LAT; k++) r_tp_tag[k] <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_tp_v[0]   <= r_vin;
            r_tp_tag[0] <= r_tag_in;
            for (int k = 1; k < M_LAT; k++) begin
                r_tp_v[k]   <= r_tp_v[k-1];
                r_tp_tag[k] <= r_tp_tag[k-1];
            end
            r_rsp_valid <= w_retire ? (NREQ'(1) << r_tp_tag[M_LAT-1]) : '0;
            if (w_mul_vout) r_rsp_data <= w_mul_res;
            if (w_mul_vout ^ r_tp_v[M_LAT-1]) r_err <= 1'b1;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign err       = r_err;
    assign busy      = (|r_tp_v) | r_vin | (|r_rsp_valid);
endmodule
`default_nettype wire
